// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and constants for the PS/2-to-Hack keyboard controller.
//   - kbd_state_e : prefix-sequencing FSM states
//   - Pfx*        : scan-code prefix bytes (E0 extended, F0 break, E1 pause)
//   - Sc*         : modifier scan codes (left/right shift, caps lock)
//   - PauseSkip   : bytes following E1 that belong to the pause sequence
//   - Ch*         : Hack special character codes 128-152
//   - letter_char : ASCII letter from alphabet index and case
package kbd_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StExt,
      StBrk,
      StExtBrk,
      StPause
   } kbd_state_e;

   localparam logic [7:0] PfxE0 = 8'hE0;
   localparam logic [7:0] PfxF0 = 8'hF0;
   localparam logic [7:0] PfxE1 = 8'hE1;

   localparam logic [7:0] ScLShift = 8'h12;
   localparam logic [7:0] ScRShift = 8'h59;
   localparam logic [7:0] ScCaps   = 8'h58;

   localparam logic [2:0] PauseSkip = 3'd7;

   localparam logic [7:0] ChEnter = 8'd128;
   localparam logic [7:0] ChBksp  = 8'd129;
   localparam logic [7:0] ChLeft  = 8'd130;
   localparam logic [7:0] ChUp    = 8'd131;
   localparam logic [7:0] ChRight = 8'd132;
   localparam logic [7:0] ChDown  = 8'd133;
   localparam logic [7:0] ChHome  = 8'd134;
   localparam logic [7:0] ChEnd   = 8'd135;
   localparam logic [7:0] ChPgUp  = 8'd136;
   localparam logic [7:0] ChPgDn  = 8'd137;
   localparam logic [7:0] ChIns   = 8'd138;
   localparam logic [7:0] ChDel   = 8'd139;
   localparam logic [7:0] ChEsc   = 8'd140;
   localparam logic [7:0] ChF1    = 8'd141;
   localparam logic [7:0] ChF2    = 8'd142;
   localparam logic [7:0] ChF3    = 8'd143;
   localparam logic [7:0] ChF4    = 8'd144;
   localparam logic [7:0] ChF5    = 8'd145;
   localparam logic [7:0] ChF6    = 8'd146;
   localparam logic [7:0] ChF7    = 8'd147;
   localparam logic [7:0] ChF8    = 8'd148;
   localparam logic [7:0] ChF9    = 8'd149;
   localparam logic [7:0] ChF10   = 8'd150;
   localparam logic [7:0] ChF11   = 8'd151;
   localparam logic [7:0] ChF12   = 8'd152;

   // idx 0..25 = a..z
   function automatic logic [7:0] letter_char(input logic [4:0] idx, input logic upper);
      return (upper ? 8'h41 : 8'h61) + {3'b000, idx};
   endfunction

endpackage

// File: rtl/kbd_if.sv
// kbd_if: byte-receiver / keyboard-register bundle for kbd_ctrl.
//   scan_valid, scan_code : one-cycle strobe and raw PS/2 set-2 byte (receiver -> controller)
//   kbd_out               : Hack keyboard word {8'h00, char}, 0 = no key
//   key_event             : one-cycle pulse per accepted mapped make
//   shift_held, caps_on   : modifier status
// master = byte source / register reader, slave = kbd_ctrl.
interface kbd_if;
   logic        scan_valid;
   logic [7:0]  scan_code;
   logic [15:0] kbd_out;
   logic        key_event;
   logic        shift_held;
   logic        caps_on;

   modport master (
      output scan_valid,
      output scan_code,
      input  kbd_out,
      input  key_event,
      input  shift_held,
      input  caps_on
   );

   modport slave (
      input  scan_valid,
      input  scan_code,
      output kbd_out,
      output key_event,
      output shift_held,
      output caps_on
   );
endinterface

// File: rtl/kbd_keymap.sv
// kbd_keymap: combinational PS/2 set-2 scan code to Hack character translation.
//   i_code  : scan code byte
//   i_ext   : code was preceded by E0
//   i_upper : letters render uppercase (shift xor caps)
//   i_shift : shift held, selects the shifted glyph of digits/punctuation
//   o_char  : Hack character, 0 for unmapped keys
module kbd_keymap
   import kbd_pkg::*;
(
   input  logic [7:0] i_code,
   input  logic       i_ext,
   input  logic       i_upper,
   input  logic       i_shift,
   output logic [7:0] o_char
);

   always_comb begin
      o_char = 8'h00;
      if (i_ext) begin
         case (i_code)
            8'h6B:   o_char = ChLeft;
            8'h75:   o_char = ChUp;
            8'h74:   o_char = ChRight;
            8'h72:   o_char = ChDown;
            8'h6C:   o_char = ChHome;
            8'h69:   o_char = ChEnd;
            8'h7D:   o_char = ChPgUp;
            8'h7A:   o_char = ChPgDn;
            8'h70:   o_char = ChIns;
            8'h71:   o_char = ChDel;
            8'h5A:   o_char = ChEnter;   // keypad enter
            default: o_char = 8'h00;
         endcase
      end else begin
         case (i_code)
            // letters
            8'h1C:   o_char = letter_char(5'd0,  i_upper);
            8'h32:   o_char = letter_char(5'd1,  i_upper);
            8'h21:   o_char = letter_char(5'd2,  i_upper);
            8'h23:   o_char = letter_char(5'd3,  i_upper);
            8'h24:   o_char = letter_char(5'd4,  i_upper);
            8'h2B:   o_char = letter_char(5'd5,  i_upper);
            8'h34:   o_char = letter_char(5'd6,  i_upper);
            8'h33:   o_char = letter_char(5'd7,  i_upper);
            8'h43:   o_char = letter_char(5'd8,  i_upper);
            8'h3B:   o_char = letter_char(5'd9,  i_upper);
            8'h42:   o_char = letter_char(5'd10, i_upper);
            8'h4B:   o_char = letter_char(5'd11, i_upper);
            8'h3A:   o_char = letter_char(5'd12, i_upper);
            8'h31:   o_char = letter_char(5'd13, i_upper);
            8'h44:   o_char = letter_char(5'd14, i_upper);
            8'h4D:   o_char = letter_char(5'd15, i_upper);
            8'h15:   o_char = letter_char(5'd16, i_upper);
            8'h2D:   o_char = letter_char(5'd17, i_upper);
            8'h1B:   o_char = letter_char(5'd18, i_upper);
            8'h2C:   o_char = letter_char(5'd19, i_upper);
            8'h3C:   o_char = letter_char(5'd20, i_upper);
            8'h2A:   o_char = letter_char(5'd21, i_upper);
            8'h1D:   o_char = letter_char(5'd22, i_upper);
            8'h22:   o_char = letter_char(5'd23, i_upper);
            8'h35:   o_char = letter_char(5'd24, i_upper);
            8'h1A:   o_char = letter_char(5'd25, i_upper);
            // digit row, US layout shifted glyphs
            8'h16:   o_char = i_shift ? 8'h21 : 8'h31;
            8'h1E:   o_char = i_shift ? 8'h40 : 8'h32;
            8'h26:   o_char = i_shift ? 8'h23 : 8'h33;
            8'h25:   o_char = i_shift ? 8'h24 : 8'h34;
            8'h2E:   o_char = i_shift ? 8'h25 : 8'h35;
            8'h36:   o_char = i_shift ? 8'h5E : 8'h36;
            8'h3D:   o_char = i_shift ? 8'h26 : 8'h37;
            8'h3E:   o_char = i_shift ? 8'h2A : 8'h38;
            8'h46:   o_char = i_shift ? 8'h28 : 8'h39;
            8'h45:   o_char = i_shift ? 8'h29 : 8'h30;
            // punctuation
            8'h4E:   o_char = i_shift ? 8'h5F : 8'h2D;
            8'h55:   o_char = i_shift ? 8'h2B : 8'h3D;
            8'h54:   o_char = i_shift ? 8'h7B : 8'h5B;
            8'h5B:   o_char = i_shift ? 8'h7D : 8'h5D;
            8'h5D:   o_char = i_shift ? 8'h7C : 8'h5C;
            8'h4C:   o_char = i_shift ? 8'h3A : 8'h3B;
            8'h52:   o_char = i_shift ? 8'h22 : 8'h27;
            8'h41:   o_char = i_shift ? 8'h3C : 8'h2C;
            8'h49:   o_char = i_shift ? 8'h3E : 8'h2E;
            8'h4A:   o_char = i_shift ? 8'h3F : 8'h2F;
            8'h0E:   o_char = i_shift ? 8'h7E : 8'h60;
            // whitespace and editing
            8'h29:   o_char = 8'h20;
            8'h5A:   o_char = ChEnter;
            8'h66:   o_char = ChBksp;
            8'h76:   o_char = ChEsc;
            // function keys
            8'h05:   o_char = ChF1;
            8'h06:   o_char = ChF2;
            8'h04:   o_char = ChF3;
            8'h0C:   o_char = ChF4;
            8'h03:   o_char = ChF5;
            8'h0B:   o_char = ChF6;
            8'h83:   o_char = ChF7;
            8'h0A:   o_char = ChF8;
            8'h01:   o_char = ChF9;
            8'h09:   o_char = ChF10;
            8'h78:   o_char = ChF11;
            8'h07:   o_char = ChF12;
            default: o_char = 8'h00;
         endcase
      end
   end

endmodule

// File: rtl/kbd_ctrl.sv
// kbd_ctrl: PS/2 scan-code sequencer driving the Hack keyboard register.
//   Parameter TIMEOUT_CYCLES : idle cycles tolerated after a prefix byte before
//                              the partial sequence is abandoned.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : kbd_if.slave (scan_valid/scan_code in; kbd_out, key_event,
//           shift_held, caps_on out, all registered)
// Optional feature: define KBD_CAPS_LOCK_EN to enable the caps-lock latch (scan
// code 58). Without it, 58 is an ordinary unmapped key and caps_on is 0.
module kbd_ctrl
   import kbd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 32'd2_500_000
) (
   input  logic clk,
   input  logic rst_n,
   kbd_if.slave bus
);

   localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TmoW-1:0] TmoLoad = TmoW'(TIMEOUT_CYCLES);

   kbd_state_e      r_state;
   logic [TmoW-1:0] r_tmo;
   logic [2:0]      r_skip;
   logic            r_lshift;
   logic            r_rshift;
   logic            r_shift_held;
   logic [7:0]      r_cur_code;
   logic            r_cur_ext;
   logic            r_cur_valid;
   logic [7:0]      r_char;
   logic            r_key_event;
`ifdef KBD_CAPS_LOCK_EN
   logic            r_caps_on;
   logic            r_caps_down;
`endif

   logic       w_done;       // byte completes a make/break sequence
   logic       w_brk;
   logic       w_ext;
   logic       w_shift;
   logic       w_caps;
   logic       w_upper;
   logic       w_is_shift;
   logic       w_cur_match;
   logic [7:0] w_char;
   logic [7:0] w_code;

   assign w_code = bus.scan_code;

   // Classify the incoming byte against the prefix context.
   always_comb begin
      w_done = 1'b0;
      w_brk  = 1'b0;
      w_ext  = 1'b0;
      if (bus.scan_valid) begin
         case (r_state)
            StIdle:   w_done = !(w_code inside {PfxE0, PfxF0, PfxE1});
            StExt: begin
               w_done = (w_code != PfxF0);
               w_ext  = 1'b1;
            end
            StBrk: begin
               w_done = 1'b1;
               w_brk  = 1'b1;
            end
            StExtBrk: begin
               w_done = 1'b1;
               w_brk  = 1'b1;
               w_ext  = 1'b1;
            end
            default:  w_done = 1'b0;
         endcase
      end
   end

`ifdef KBD_CAPS_LOCK_EN
   assign w_caps = r_caps_on;
`else
   assign w_caps = 1'b0;
`endif

   assign w_shift     = r_lshift | r_rshift;
   assign w_upper     = w_shift ^ w_caps;
   // E0-prefixed 12/59 are fake shifts and must not touch modifier state.
   assign w_is_shift  = !w_ext && ((w_code == ScLShift) || (w_code == ScRShift));
   assign w_cur_match = r_cur_valid && (r_cur_code == w_code) && (r_cur_ext == w_ext);

   kbd_keymap u_keymap (
      .i_code  (w_code),
      .i_ext   (w_ext),
      .i_upper (w_upper),
      .i_shift (w_shift),
      .o_char  (w_char)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StIdle;
         r_tmo        <= '0;
         r_skip       <= '0;
         r_lshift     <= 1'b0;
         r_rshift     <= 1'b0;
         r_shift_held <= 1'b0;
         r_cur_code   <= '0;
         r_cur_ext    <= 1'b0;
         r_cur_valid  <= 1'b0;
         r_char       <= '0;
         r_key_event  <= 1'b0;
`ifdef KBD_CAPS_LOCK_EN
         r_caps_on    <= 1'b0;
         r_caps_down  <= 1'b0;
`endif
      end else begin
         r_key_event <= 1'b0;

         // Prefix sequencing; a byte in the expiry cycle wins over the timeout.
         if (bus.scan_valid) begin
            case (r_state)
               StIdle: begin
                  if (w_code == PfxE0) begin
                     r_state <= StExt;
                     r_tmo   <= TmoLoad;
                  end else if (w_code == PfxF0) begin
                     r_state <= StBrk;
                     r_tmo   <= TmoLoad;
                  end else if (w_code == PfxE1) begin
                     r_state <= StPause;
                     r_skip  <= PauseSkip;
                     r_tmo   <= TmoLoad;
                  end
               end
               StExt: begin
                  if (w_code == PfxF0) begin
                     r_state <= StExtBrk;
                     r_tmo   <= TmoLoad;
                  end else begin
                     r_state <= StIdle;
                  end
               end
               StPause: begin
                  if (r_skip <= 3'd1) begin
                     r_state <= StIdle;
                     r_skip  <= '0;
                  end else begin
                     r_skip  <= r_skip - 3'd1;
                     r_tmo   <= TmoLoad;
                  end
               end
               default: r_state <= StIdle;   // StBrk, StExtBrk: byte completes the break
            endcase
         end else if (r_state != StIdle) begin
            if (r_tmo == '0) begin
               r_state <= StIdle;
               r_skip  <= '0;
            end else begin
               r_tmo <= r_tmo - TmoW'(1);
            end
         end

         if (w_done) begin
            if (w_is_shift) begin
               if (w_code == ScLShift) begin
                  r_lshift     <= !w_brk;
                  r_shift_held <= !w_brk || r_rshift;
               end else begin
                  r_rshift     <= !w_brk;
                  r_shift_held <= !w_brk || r_lshift;
               end
            end

`ifdef KBD_CAPS_LOCK_EN
            // caps_down suppresses typematic repeats of the caps key.
            if (!w_ext && (w_code == ScCaps)) begin
               if (w_brk) begin
                  r_caps_down <= 1'b0;
               end else if (!r_caps_down) begin
                  r_caps_on   <= !r_caps_on;
                  r_caps_down <= 1'b1;
               end
            end
`endif

            if (!w_brk && (w_char != 8'h00)) begin
               r_cur_code  <= w_code;
               r_cur_ext   <= w_ext;
               r_cur_valid <= 1'b1;
               r_char      <= w_char;
               r_key_event <= 1'b1;
            end else if (w_brk && w_cur_match) begin
               r_char      <= 8'h00;
               r_cur_valid <= 1'b0;
            end
         end
      end
   end

   assign bus.kbd_out    = {8'h00, r_char};
   assign bus.key_event  = r_key_event;
   assign bus.shift_held = r_shift_held;
`ifdef KBD_CAPS_LOCK_EN
   assign bus.caps_on    = r_caps_on;
`else
   assign bus.caps_on    = 1'b0;
`endif

endmodule

// File: tb/tb_kbd_ctrl.sv
// tb_kbd_ctrl: self-checking bench for kbd_ctrl. A byte-level reference model
// (prefix grammar on a queue, table-driven keymap) predicts every output each
// cycle; directed sequences pin literal values, then randomized traffic runs.
module tb_kbd_ctrl;

   localparam int TMO = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   kbd_if bus ();

   kbd_ctrl #(
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference keymap tables
   byte unsigned lt_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                   8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                   8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                   8'h35, 8'h1A};
   byte unsigned sy_codes [21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                   8'h46, 8'h45, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C,
                                   8'h52, 8'h41, 8'h49, 8'h4A, 8'h0E};
   int           sy_lo [21] = '{49, 50, 51, 52, 53, 54, 55, 56, 57, 48, 45, 61, 91, 93, 92,
                                59, 39, 44, 46, 47, 96};
   int           sy_hi [21] = '{33, 64, 35, 36, 37, 94, 38, 42, 40, 41, 95, 43, 123, 125, 124,
                                58, 34, 60, 62, 63, 126};
   byte unsigned fk_codes [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A,
                                   8'h01, 8'h09, 8'h78, 8'h07};
   byte unsigned ex_codes [11] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A,
                                   8'h70, 8'h71, 8'h5A};
   int           ex_vals  [11] = '{130, 131, 132, 133, 134, 135, 136, 137, 138, 139, 128};

   byte unsigned pool_n [16] = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h4E, 8'h29, 8'h5A, 8'h66,
                                 8'h76, 8'h05, 8'h83, 8'h12, 8'h59, 8'h58, 8'h0D, 8'h14};
   byte unsigned pool_e [8]  = '{8'h75, 8'h6B, 8'h5A, 8'h12, 8'h59, 8'h1F, 8'h71, 8'h70};
   byte unsigned pause_seq [7] = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

   // Model state
   byte unsigned m_pend [$];   // prefix bytes of the sequence in progress
   int m_pause, m_idle, m_out, m_cur_code;
   bit m_lsh, m_rsh, m_caps, m_caps_dn, m_cur_v, m_cur_ext, m_ev;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int m_map(input int code, input bit ext, input bit up, input bit sh);
      if (ext) begin
         for (int i = 0; i < 11; i++) if (code == int'(ex_codes[i])) return ex_vals[i];
         return 0;
      end
      for (int i = 0; i < 26; i++) if (code == int'(lt_codes[i])) return (up ? 65 : 97) + i;
      for (int i = 0; i < 21; i++)
         if (code == int'(sy_codes[i])) return sh ? sy_hi[i] : sy_lo[i];
      for (int i = 0; i < 12; i++) if (code == int'(fk_codes[i])) return 141 + i;
      if (code == 'h29) return 32;
      if (code == 'h5A) return 128;
      if (code == 'h66) return 129;
      if (code == 'h76) return 140;
      return 0;
   endfunction

   function automatic void m_reset();
      m_pend.delete();
      m_pause = 0; m_idle = 0; m_out = 0; m_cur_code = 0;
      m_lsh = 0; m_rsh = 0; m_caps = 0; m_caps_dn = 0; m_cur_v = 0; m_cur_ext = 0; m_ev = 0;
   endfunction

   function automatic void m_apply(input int code, input bit ext, input bit brk);
      int ch;
      if (!ext && (code == 'h12 || code == 'h59)) begin
         if (code == 'h12) m_lsh = !brk;
         else m_rsh = !brk;
         return;
      end
`ifdef KBD_CAPS_LOCK_EN
      if (!ext && code == 'h58) begin
         if (brk) m_caps_dn = 0;
         else if (!m_caps_dn) begin
            m_caps = !m_caps;
            m_caps_dn = 1;
         end
         return;
      end
`endif
      if (!brk) begin
         ch = m_map(code, ext, (m_lsh | m_rsh) ^ m_caps, m_lsh | m_rsh);
         if (ch != 0) begin
            m_cur_v = 1; m_cur_code = code; m_cur_ext = ext; m_out = ch; m_ev = 1;
         end
      end else if (m_cur_v && m_cur_code == code && m_cur_ext == ext) begin
         m_out = 0;
         m_cur_v = 0;
      end
   endfunction

   // Advance the model by one clock with the given input.
   function automatic void m_step(input bit v, input int b);
      bit ext, brk;
      m_ev = 0;
      if (v) begin
         m_idle = 0;
         if (m_pause > 0) m_pause--;
         else if (m_pend.size() == 0 && b == 'hE1) m_pause = 7;
         else if ((m_pend.size() == 0 && (b == 'hE0 || b == 'hF0)) ||
                  (m_pend.size() == 1 && m_pend[0] == 8'hE0 && b == 'hF0))
            m_pend.push_back(8'(b));
         else begin
            ext = (m_pend.size() > 0) && (m_pend[0] == 8'hE0);
            brk = 0;
            foreach (m_pend[i]) if (m_pend[i] == 8'hF0) brk = 1;
            m_pend.delete();
            m_apply(b, ext, brk);
         end
      end else if (m_pend.size() > 0 || m_pause > 0) begin
         m_idle++;
         if (m_idle > TMO) begin
            m_pend.delete();
            m_pause = 0;
            m_idle = 0;
         end
      end
   endfunction

   task automatic cycle(input bit v, input logic [7:0] b);
      @(negedge clk);
      chk("kbd_out",    int'(bus.kbd_out),    m_out);
      chk("key_event",  int'(bus.key_event),  int'(m_ev));
      chk("shift_held", int'(bus.shift_held), int'(m_lsh | m_rsh));
      chk("caps_on",    int'(bus.caps_on),    int'(m_caps));
      bus.scan_valid = v;
      bus.scan_code  = v ? b : 8'h00;
      m_step(v, int'(b));
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b1, b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
   endtask

   task automatic gap();
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.scan_valid = 1'b0;
      bus.scan_code  = 8'h00;
      rst_n = 1'b0;
      m_reset();
      #1;
      chk("rst_kbd_out", int'(bus.kbd_out), 0);
      chk("rst_shift",   int'(bus.shift_held), 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int act, n, b;
      bit caps_build;
`ifdef KBD_CAPS_LOCK_EN
      caps_build = 1'b1;
`else
      caps_build = 1'b0;
`endif
      bus.scan_valid = 1'b0;
      bus.scan_code  = 8'h00;
      m_reset();
      repeat (3) @(negedge clk);
      chk("reset_kbd_out",   int'(bus.kbd_out),    0);
      chk("reset_key_event", int'(bus.key_event),  0);
      chk("reset_shift",     int'(bus.shift_held), 0);
      chk("reset_caps",      int'(bus.caps_on),    0);
      rst_n = 1'b1;

      // make/break of 'a'
      send(8'h1C); idle(1);
      chk("a_make", int'(bus.kbd_out), 97);
      chk("a_event", int'(bus.key_event), 1);
      idle(1);
      chk("a_event_once", int'(bus.key_event), 0);
      send(8'hF0); send(8'h1C); idle(1);
      chk("a_break", int'(bus.kbd_out), 0);

      // shifted 'A'
      send(8'h12); idle(1);
      chk("lshift_down", int'(bus.shift_held), 1);
      send(8'h1C); idle(1);
      chk("A_make", int'(bus.kbd_out), 65);
      send(8'hF0); send(8'h1C); idle(1);
      chk("A_break", int'(bus.kbd_out), 0);
      chk("lshift_still", int'(bus.shift_held), 1);
      send(8'hF0); send(8'h12); idle(1);
      chk("lshift_up", int'(bus.shift_held), 0);

      // extended arrow and fake shift
      send(8'hE0); send(8'h75); idle(1);
      chk("up_make", int'(bus.kbd_out), 131);
      send(8'hE0); send(8'hF0); send(8'h75); idle(1);
      chk("up_break", int'(bus.kbd_out), 0);
      send(8'hE0); send(8'h12); idle(1);
      chk("fake_shift", int'(bus.shift_held), 0);
      send(8'hE0); send(8'hF0); send(8'h12);

      // rollover
      send(8'h1C); idle(1);
      chk("roll_a", int'(bus.kbd_out), 97);
      send(8'h32); idle(1);
      chk("roll_b", int'(bus.kbd_out), 98);
      send(8'hF0); send(8'h1C); idle(1);
      chk("roll_old_break", int'(bus.kbd_out), 98);
      send(8'hF0); send(8'h32); idle(1);
      chk("roll_cur_break", int'(bus.kbd_out), 0);

      // pause sequence produces nothing
      send(8'h1C);
      send(8'hE1);
      for (int i = 0; i < 7; i++) send(pause_seq[i]);
      idle(1);
      chk("pause_hold", int'(bus.kbd_out), 97);
      chk("pause_no_event", int'(bus.key_event), 0);
      send(8'h29); idle(1);
      chk("space_after_pause", int'(bus.kbd_out), 32);
      send(8'hF0); send(8'h29); send(8'hF0); send(8'h1C);

      // timeout boundary
      send(8'hE0); idle(TMO + 1); send(8'h1C); idle(1);
      chk("tmo_expired", int'(bus.kbd_out), 97);
      send(8'hF0); send(8'h1C);
      send(8'hE0); idle(TMO); send(8'h75); idle(1);
      chk("tmo_expiry_cycle_byte", int'(bus.kbd_out), 131);
      send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hF0); idle(TMO + 1); send(8'h32); idle(1);
      chk("brk_tmo", int'(bus.kbd_out), 98);
      send(8'hF0); send(8'h32);

      // caps lock
      send(8'h58); idle(1);
      chk("caps_first", int'(bus.caps_on), int'(caps_build));
      send(8'h58); send(8'hF0); send(8'h58); idle(1);
      chk("caps_repeat", int'(bus.caps_on), int'(caps_build));
      send(8'h1C); idle(1);
      chk("caps_letter", int'(bus.kbd_out), caps_build ? 65 : 97);
      send(8'hF0); send(8'h1C);

      // reset mid-sequence
      send(8'hE0); send(8'hF0);
      do_reset();
      send(8'h1C); idle(1);
      chk("rst_extbrk_then_a", int'(bus.kbd_out), 97);
      send(8'hE1); send(8'h14);
      do_reset();
      send(8'h29); idle(1);
      chk("rst_pause_then_space", int'(bus.kbd_out), 32);
      send(8'hF0); send(8'h29);

      // randomized traffic
      for (int k = 0; k < 1200; k++) begin
         act = $urandom_range(0, 11);
         case (act)
            0, 1, 2, 3: begin
               if ($urandom_range(0, 3) == 0) begin
                  send(8'hE0); gap(); send(pool_e[$urandom_range(0, 7)]);
               end else send(pool_n[$urandom_range(0, 15)]);
            end
            4, 5: begin
               if ($urandom_range(0, 3) == 0) begin
                  send(8'hE0); gap(); send(8'hF0); gap(); send(pool_e[$urandom_range(0, 7)]);
               end else begin
                  send(8'hF0); gap(); send(pool_n[$urandom_range(0, 15)]);
               end
            end
            6: begin
               n = $urandom_range(1, 8);
               send(8'hE1);
               for (int i = 0; i < n - 1; i++) begin
                  gap(); send(pause_seq[i]);
               end
            end
            7: begin
               b = $urandom_range(0, 2);
               send(b == 0 ? 8'hE0 : (b == 1 ? 8'hF0 : 8'hE1));
               idle($urandom_range(TMO - 1, TMO + 2));
               send(pool_n[$urandom_range(0, 15)]);
            end
            8: send(8'($urandom_range(0, 255)));
            9: idle($urandom_range(0, 5));
            10: begin
               if ($urandom_range(0, 19) == 0) do_reset();
               else send(8'($urandom_range(0, 255)));
            end
            default: begin
               b = int'(pool_n[$urandom_range(0, 15)]);
               send(8'(b)); gap(); send(8'hF0); gap(); send(8'(b));
            end
         endcase
         gap();
      end
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
